// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns status and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first, one carry flop.
// The result appears on sum/cout together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_full;

  assign bit_s    = ra_q[0] ^ rb_q[0] ^ carry_q;
  assign bit_c    = (ra_q[0] & rb_q[0]) | (carry_q & (ra_q[0] ^ rb_q[0]));
  // Partial result keeps only the bits already produced; the newest bit enters at the MSB.
  assign res_full = {bit_s, res_q};

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        carry_d = bit_c;
        res_d   = res_full[WIDTH-1:1];
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_full;
          cout_d  = bit_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: expected results are queued when an
// operation is started and compared when done pulses.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt;
  exp_t sb[$];
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    sb.push_back(e);
  endfunction

  // Output monitor: compares results on done, otherwise requires sum/cout to hold.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_outs", {22'd0, bus.busy, bus.done, bus.cout, bus.sum}, 32'd0);
      prev_sum  = '0;
      prev_cout = 1'b0;
    end else if (bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done: sum=%02h cout=%0d (expected sum=%02h cout=%0d)", bus.sum, bus.cout, e.sum, e.cout);
        check("sum", {24'd0, bus.sum}, {24'd0, e.sum});
        check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
      end
      prev_sum  = bus.sum;
      prev_cout = bus.cout;
    end else begin
      check("hold", {23'd0, bus.cout, bus.sum}, {23'd0, prev_cout, prev_sum});
    end
  end

  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    bus.start = 1'b1;
    push_exp(av, bv, cv);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < W + 4);
    check("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output int busy_n, output int lat);
    drive_start(av, bv, cv);
    @(negedge clk);
    bus.start = 1'b0;
    lat    = 1;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < W + 4) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
    end
    check("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    int bn, lt, n, d0;
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    prev_sum = '0;
    prev_cout = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset values visible before any clock edge
    #1;
    check("reset_outs", {22'd0, bus.busy, bus.done, bus.cout, bus.sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic op: latency and busy length
    run_op(8'h35, 8'h1A, 1'b0, bn, lt);
    check("busy_len", bn, W);
    check("latency", lt, W + 1);

    run_op(8'hFF, 8'h01, 1'b0, bn, lt);
    run_op(8'hFF, 8'hFF, 1'b1, bn, lt);
    run_op(8'h00, 8'h00, 1'b1, bn, lt);
    check("busy_len_cin", bn, W);

    // Start while busy must be ignored
    d0 = done_cnt;
    drive_start(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    repeat (W + 2) @(negedge clk);
    check("ignored_start_dones", done_cnt - d0, 1);
    check("ignored_start_sb", sb.size(), 0);

    // Asynchronous reset mid-operation
    d0 = done_cnt;
    drive_start(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_outs", {22'd0, bus.busy, bus.done, bus.cout, bus.sum}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    run_op(8'h02, 8'h03, 1'b0, bn, lt);
    check("post_rst_latency", lt, W + 1);

    // Back-to-back: start held through DONE
    drive_start(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    bus.a   = 8'h80;
    bus.b   = 8'h80;
    bus.cin = 1'b0;
    push_exp(8'h80, 8'h80, 1'b0);
    wait_done(n);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    check("b2b_gap", n + 1, W + 1);

    // Random sweep
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), bn, lt);
      check("rand_busy_len", bn, W);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
